dot2_operand_packer: RTL and testbench
======================================

# dot2_operand_packer

Upstream feeder for the combinational 2-element dot-product stage. Accepts one signed (a, b) element pair per handshake beat from a serial stream, assembles N-lane packed operand vectors, and presents them as registered arg_0/arg_1 buses with a valid/ready handshake. Short vectors, marked by an early last, are zero-padded. Throughput is one vector per N accepted beats, with no bubbles when the consumer is always ready.

## Interface
- N, 2, vector length (lanes per operand vector), N ≥ 2
- W, 8, signed element width
- LW, $clog2(N+1), width of out_len
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  element pair valid
- in_ready  out  1  element pair accepted when in_valid && in_ready
- in_a  in  W  signed element for operand vector 0
- in_b  in  W  signed element for operand vector 1
- in_last  in  1  this pair ends the current vector
- out_valid  out  1  packed vectors valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_arg_0  out  [N-1:0][W-1:0]  packed vector 0, lane k = k-th accepted element
- out_arg_1  out  [N-1:0][W-1:0]  packed vector 1
- out_len  out  LW  number of real (non-padded) lanes, 1..N

## Operation
- State: lane index idx (0..N-1), fill buffers fa/fb ([N-1:0][W-1:0]), output register (arg_0, arg_1, len, valid).
- completing = (idx == N-1) || in_last.
- in_ready = !completing || !out_valid || out_ready. This is a combinational function of in_last, idx, out_valid, and out_ready. Non-final beats are never stalled.
- Accepted non-completing beat: fa[idx] <= in_a, fb[idx] <= in_b, idx <= idx+1.
- Accepted completing beat: output register <= fill buffers with lane idx replaced by in_a/in_b. Lanes above idx come from the fill buffers, which are already zero. len <= idx+1, out_valid <= 1, fa/fb <= 0, idx <= 0.
- in_last at idx == N-1 is redundant. A vector always closes at N elements; in_last is not required.
- Output consumed (out_valid && out_ready) with no completing beat: out_valid <= 0. Data holds its value, don't-care.
- Output consumed and completing beat accepted in the same cycle: the new vector loads and out_valid stays 1.
- Output data is stable while out_valid && !out_ready.
- Elements are passed bit-exact, with no arithmetic and no sign extension. Padding lanes are all-zero, so the dot-product contribution is 0.

## Timing
- Reset values: out_valid=0, out_arg_0=0, out_arg_1=0, out_len=0, idx=0, fill buffers 0. in_ready=1 in the first cycle after reset.
- Latency: the vector is visible on the outputs the cycle after its completing beat is accepted.
- Sustained rate: N beats per vector with out_ready held high, no idle cycles.
- Backpressure: only the completing beat stalls. Earlier lanes continue filling while the previous vector is held.
- Reset mid-vector: the partial vector is discarded, with no emission. A pending output is dropped (out_valid=0 next cycle).
- in_valid low: no state change except output consumption.

## Structure
- Shared package dot2_pkg: default N and W, typedef elem_t (logic signed [W-1:0]), typedef vec_t ([N-1:0] elem_t). The dot-product stage imports the same package.
- No sub-module. A flat single module of about 150 lines.
- This block is instanced alongside the dot-product stage in a top-level wrapper, out_arg_0/1 → arg_0/1.

## Test plan
- Full vectors, out_ready=1: beats (3,4),(−2,5) → one cycle later out_arg_0={lane1=0xFE,lane0=0x03}, out_arg_1={0x05,0x04}, out_len=2, valid one cycle. Back-to-back vectors show no gap in in_ready.
- Short vector: single beat (7,−1) with in_last=1 → out_arg_0={0x00,0x07}, out_arg_1={0x00,0xFF}, out_len=1.
- Backpressure: out_ready=0 with one vector held. Send lane 0 of the next vector → accepted. Lane 1 → in_ready=0 until out_ready=1, then the new vector replaces the old one in the same cycle with out_valid staying 1.
- Extremes: (−128,−128),(127,127) → lanes 0x80 and 0x7F preserved exactly.
- Reset mid-vector: accept lane 0 = (9,9), assert rst one cycle, then send (1,2),(3,4) → output {3,1}/{4,2}. No trace of 9.
- Random stream with random in_valid/out_ready and in_last: a scoreboard checks every emitted vector, len, and zero padding. No loss or duplication.

Source files
------------

// File: rtl/dot2_pkg.sv
// Shared types and defaults for the 2-element dot-product datapath.
// Imported by the operand packer and by the dot-product stage.
package dot2_pkg;

  localparam int unsigned N_DEF = 2;  // default lanes per operand vector
  localparam int unsigned W_DEF = 8;  // default signed element width

  typedef logic signed [W_DEF-1:0] elem_t;
  typedef elem_t [N_DEF-1:0]       vec_t;

endpackage

// File: rtl/dot2_operand_packer.sv
// dot2_operand_packer: collects one signed (a, b) element pair per accepted
// beat and assembles N-lane operand vectors for the dot-product stage.
// A beat with in_last set closes a short vector. The missing lanes are
// zero-padded.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_valid / in_ready    element-pair handshake. in_ready is combinational.
//   in_a, in_b             elements for operand vector 0 / 1
//   in_last                this pair closes the current vector
//   out_valid / out_ready  packed-vector handshake
//   out_arg_0, out_arg_1   registered packed vectors, lane k = k-th element
//   out_len                number of real (non-padded) lanes, 1..N
module dot2_operand_packer
  import dot2_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned W  = W_DEF,
  parameter int unsigned LW = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_a,
  input  logic [W-1:0]        in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0][W-1:0] out_arg_0,
  output logic [N-1:0][W-1:0] out_arg_1,
  output logic [LW-1:0]       out_len
);

  localparam int unsigned IW       = $clog2(N);
  localparam int unsigned LAST_IDX = N - 1;

  logic [IW-1:0]        idx, idx_n;
  logic [N-1:0][W-1:0]  fa, fa_n, fb, fb_n;
  logic [N-1:0][W-1:0]  arg0_n, arg1_n;
  logic [LW-1:0]        len_n;
  logic                 valid_n;
  logic                 completing_c;
  logic                 accept_c;

  // Only a completing beat has to wait for the output register to free up.
  always_comb begin
    completing_c = (idx == IW'(LAST_IDX)) || in_last;
    in_ready     = !completing_c || !out_valid || out_ready;
    accept_c     = in_valid && in_ready;
  end

  // Next-state: fill the lane buffers, or close the vector into the output register.
  always_comb begin
    idx_n   = idx;
    fa_n    = fa;
    fb_n    = fb;
    arg0_n  = out_arg_0;
    arg1_n  = out_arg_1;
    len_n   = out_len;
    valid_n = out_valid;

    if (out_valid && out_ready) begin
      valid_n = 1'b0;
    end

    if (accept_c) begin
      if (completing_c) begin
        // Lanes above idx are still zero in the fill buffers, which gives the padding.
        arg0_n      = fa;
        arg1_n      = fb;
        arg0_n[idx] = in_a;
        arg1_n[idx] = in_b;
        len_n       = LW'(idx) + LW'(1);
        valid_n     = 1'b1;
        fa_n        = '0;
        fb_n        = '0;
        idx_n       = '0;
      end else begin
        fa_n[idx] = in_a;
        fb_n[idx] = in_b;
        idx_n     = idx + IW'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      fa        <= '0;
      fb        <= '0;
      out_arg_0 <= '0;
      out_arg_1 <= '0;
      out_len   <= '0;
      out_valid <= 1'b0;
    end else begin
      idx       <= idx_n;
      fa        <= fa_n;
      fb        <= fb_n;
      out_arg_0 <= arg0_n;
      out_arg_1 <= arg1_n;
      out_len   <= len_n;
      out_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_dot2_operand_packer.sv
// Bench for dot2_operand_packer: directed vectors with literal expectations
// plus a stream-level model and scoreboard compared on every falling edge.
module tb_dot2_operand_packer;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int LW = $clog2(N + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        in_a;
  logic [W-1:0]        in_b;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0][W-1:0] out_arg_0;
  logic [N-1:0][W-1:0] out_arg_1;
  logic [LW-1:0]       out_len;

  dot2_operand_packer #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_arg_0 (out_arg_0),
    .out_arg_1 (out_arg_1),
    .out_len   (out_len)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int emitted  = 0;
  bit rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- stream model ----------------
  typedef struct {
    logic [N-1:0][W-1:0] a;
    logic [N-1:0][W-1:0] b;
    int                  len;
  } vec_s;

  vec_s                q[$];
  vec_s                e;
  bit                  m_live = 1'b0;
  int                  m_cnt;
  logic [N-1:0][W-1:0] m_fa, m_fb, m_oa, m_ob;
  int                  m_len;
  bit                  m_valid;
  bit                  m_comp, m_ready;

  always @(negedge clk) begin
    m_comp  = (m_cnt == N - 1) || (in_last === 1'b1);
    m_ready = !m_comp || !m_valid || (out_ready === 1'b1);
    if (m_live) begin
      chk("cyc_in_ready", 64'(in_ready), 64'(m_ready));
      chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("cyc_arg0", 64'(out_arg_0), 64'(m_oa));
        chk("cyc_arg1", 64'(out_arg_1), 64'(m_ob));
        chk("cyc_len", 64'(out_len), 64'(m_len));
      end
    end
    if (rst === 1'b1) begin
      m_cnt = 0; m_fa = '0; m_fb = '0; m_oa = '0; m_ob = '0;
      m_len = 0; m_valid = 1'b0; q.delete(); m_live = 1'b1;
    end else if (m_live) begin
      if (m_valid && out_ready) begin
        m_valid = 1'b0;
        if (q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("sb_arg0", 64'(out_arg_0), 64'(e.a));
          chk("sb_arg1", 64'(out_arg_1), 64'(e.b));
          chk("sb_len", 64'(out_len), 64'(e.len));
          emitted++;
        end
      end
      if (in_valid && m_ready) begin
        m_fa[m_cnt] = in_a;
        m_fb[m_cnt] = in_b;
        if (m_comp) begin
          e.a = m_fa; e.b = m_fb; e.len = m_cnt + 1;
          q.push_back(e);
          m_oa = m_fa; m_ob = m_fb; m_len = m_cnt + 1; m_valid = 1'b1;
          m_fa = '0; m_fb = '0; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic last, output int stalls);
    bit done;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    stalls = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else stalls++;
      tick();
      if (!done && stalls > 200) begin
        chk("send_timeout", 64'(stalls), 64'd0);
        done = 1'b1;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  int s;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_arg0", 64'(out_arg_0), 64'd0);
    chk("rst_arg1", 64'(out_arg_1), 64'd0);
    chk("rst_len", 64'(out_len), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Full vector.
    send(8'd3, 8'd4, 1'b0, s);
    send(8'hFE, 8'd5, 1'b0, s);
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_arg0", 64'(out_arg_0), 64'h0000_FE03);
    chk("full_arg1", 64'(out_arg_1), 64'h0000_0504);
    chk("full_len", 64'(out_len), 64'd2);
    idle(1);
    chk("full_one_cycle", 64'(out_valid), 64'd0);

    // Back-to-back with the consumer always ready.
    for (int i = 0; i < 6; i++) begin
      send(8'(i), 8'(i + 10), 1'b0, s);
      chk("b2b_no_stall", 64'(s), 64'd0);
    end
    idle(2);

    // Short vector.
    send(8'd7, 8'hFF, 1'b1, s);
    chk("short_arg0", 64'(out_arg_0), 64'h0000_0007);
    chk("short_arg1", 64'(out_arg_1), 64'h0000_00FF);
    chk("short_len", 64'(out_len), 64'd1);
    idle(2);

    // Backpressure.
    out_ready = 1'b0;
    send(8'd1, 8'd1, 1'b0, s);
    send(8'd2, 8'd2, 1'b0, s);
    send(8'd5, 8'd6, 1'b0, s);
    chk("bp_lane0_no_stall", 64'(s), 64'd0);
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd8; in_last = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_hold_arg0", 64'(out_arg_0), 64'h0000_0201);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_swap_valid", 64'(out_valid), 64'd1);
    chk("bp_swap_arg0", 64'(out_arg_0), 64'h0000_0705);
    chk("bp_swap_arg1", 64'(out_arg_1), 64'h0000_0806);
    chk("bp_swap_len", 64'(out_len), 64'd2);
    idle(2);

    // Extremes pass bit-exact.
    send(8'h80, 8'h80, 1'b0, s);
    send(8'h7F, 8'h7F, 1'b0, s);
    chk("ext_arg0", 64'(out_arg_0), 64'h0000_7F80);
    chk("ext_arg1", 64'(out_arg_1), 64'h0000_7F80);
    idle(2);

    // Reset mid-vector discards the partial lane.
    send(8'd9, 8'd9, 1'b0, s);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(8'd1, 8'd2, 1'b0, s);
    send(8'd3, 8'd4, 1'b0, s);
    chk("rstmid_arg0", 64'(out_arg_0), 64'h0000_0301);
    chk("rstmid_arg1", 64'(out_arg_1), 64'h0000_0402);
    chk("rstmid_len", 64'(out_len), 64'd2);

    // Reset drops a pending output.
    out_ready = 1'b0;
    idle(1);
    chk("rstdrop_pending", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstdrop_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    idle(1);

    // Random stream, random gaps, random consumer.
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      idle($urandom_range(0, 2));
      send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0), s);
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(4);
    chk("rand_drained", 64'(q.size()), 64'd0);
    if (emitted < 100) chk("rand_emitted_min", 64'(emitted), 64'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
